mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, sets the byte-address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, sets the width of the data ports; DATA_WIDTH/8 byte enables.
REQ-003 Parameter MEM_LATENCY, default 2, is the number of cycles the unified memory needs per access; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset is synchronous and active-low.
REQ-006 if_req  in  1  fetch stage requests an instruction read.
REQ-007 if_addr  in  ADDRESS_WIDTH  fetch address (PC).
REQ-008 if_rdata  out  DATA_WIDTH  fetched instruction, valid when if_ready=1.
REQ-009 if_ready  out  1  fetch access completes this cycle.
REQ-010 d_req  in  1  memory stage requests a load or store.
REQ-011 d_we  in  1  1=store, 0=load.
REQ-012 d_addr  in  ADDRESS_WIDTH  data address (ALU result).
REQ-013 d_wdata  in  DATA_WIDTH  store data.
REQ-014 d_be  in  DATA_WIDTH/8  byte enables (all ones for sw, one-hot for sb).
REQ-015 d_rdata  out  DATA_WIDTH  load data, valid when d_ready=1.
REQ-016 d_ready  out  1  data access completes this cycle.
REQ-017 mem_en, mem_we  out  1 each  memory enable and write strobe.
REQ-018 mem_addr, mem_wdata, mem_be  out  ADDRESS_WIDTH / DATA_WIDTH / DATA_WIDTH/8  memory address, write data, byte enables.
REQ-019 mem_rdata  in  DATA_WIDTH  memory read data, valid in the last cycle of an access.
REQ-020 stall_f, stall_m  out  1 each  stall requests to the pipeline hazard logic.

Function
REQ-021 FSM states: IDLE, FETCH, DATA.
REQ-022 In IDLE with exactly one request high, that requester is granted; with both high, the requester not recorded in last_grant is granted (round-robin on conflict).
REQ-023 On a grant edge: address, we, wdata, and be are latched (fetch: we=0, be=all ones); the state moves to FETCH or DATA; the counter loads MEM_LATENCY-1; last_grant is updated.
REQ-024 In FETCH/DATA: mem_en=1; mem_addr/we/wdata/be are driven from the latched values; requester input changes are ignored until completion.
REQ-025 The counter decrements each cycle; the cycle with counter=0 is the completion cycle.
REQ-026 In the completion cycle, the granted requester's ready=1 and its rdata=mem_rdata (combinational); the FSM returns to IDLE on the next edge.
REQ-027 Latency: a request accepted in IDLE at cycle T completes at T+MEM_LATENCY; at least one IDLE cycle separates consecutive accesses.
REQ-028 Outside its completion cycle, each ready=0 and each rdata=0; a store completion also drives d_rdata=mem_rdata, which the pipeline ignores.
REQ-029 In IDLE, mem_en=0, mem_we=0, mem_be=0, and mem_addr/mem_wdata=0.
REQ-030 stall_f = if_req AND NOT if_ready; stall_m = d_req AND NOT d_ready (combinational).
REQ-031 A requester holding req high through its ready cycle is treated as a new request in the following IDLE cycle.
REQ-032 A request raised while the other requester is in service waits; it is not lost and is granted in the next IDLE cycle.

Reset
REQ-033 While rst_n=0 at a rising edge: state←IDLE, counter←0, last_grant←FETCH, and the latched address/data/be←0.
REQ-034 During and after reset, all outputs are 0.
REQ-035 Reset during FETCH/DATA abandons the access with no ready pulse; the access is not retried.
REQ-036 After reset, the first conflicting request pair is granted to data.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x0000_0010, mem_rdata=0x0050_0093 at completion -> if_ready=1 at T+2 with if_rdata=0x0050_0093; mem_en high for exactly 2 cycles.
REQ-038 Conflict after reset: if_req=d_req=1 at T -> DATA granted, d_ready at T+2; FETCH granted at T+3, if_ready at T+5; stall_f=1 for cycles T..T+4.
REQ-039 Store byte: d_req=1, d_we=1, d_addr=0x0000_0103, d_be=4'b1000, d_wdata=0xAB00_0000 -> mem_we=1, mem_be=4'b1000, mem_addr=0x0000_0103 for 2 cycles; d_ready at T+2.
REQ-040 Both requests held continuously for 6 accesses -> grants alternate D,F,D,F,D,F, with no requester served twice in a row.
REQ-041 rst_n=0 in the second cycle of a DATA access -> no d_ready, all outputs 0 the next cycle; a subsequent if_req is granted normally.
REQ-042 MEM_LATENCY=1 build: single fetch request at T -> if_ready at T+1; back-to-back requests complete every 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between the instruction fetch
// stage and the memory (load/store) stage. A three-state FSM grants one
// requester at a time, holds the latched access for MEM_LATENCY cycles and
// alternates between requesters when both ask at once.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  output logic                      if_ready,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDRESS_WIDTH-1:0]  d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_ready,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      stall_f,
  output logic                      stall_m
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] LOAD_COUNT = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t                     state;
  state_t                     last_grant;
  logic [3:0]                 count;
  logic [ADDRESS_WIDTH-1:0]   lat_addr;
  logic                       lat_we;
  logic [DATA_WIDTH-1:0]      lat_wdata;
  logic [BE_WIDTH-1:0]        lat_be;

  logic                       busy;
  logic                       done;

  // Grant/serve FSM: arbitration in IDLE, latency countdown while serving.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= FETCH;
      count      <= 4'd0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      lat_be     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Data wins when alone, or on conflict when fetch was served last.
          if (d_req && (!if_req || (last_grant == FETCH))) begin
            state      <= DATA;
            last_grant <= DATA;
            count      <= LOAD_COUNT;
            lat_addr   <= d_addr;
            lat_we     <= d_we;
            lat_wdata  <= d_wdata;
            lat_be     <= d_be;
          end else if (if_req) begin
            state      <= FETCH;
            last_grant <= FETCH;
            count      <= LOAD_COUNT;
            lat_addr   <= if_addr;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            lat_be     <= '1;
          end else begin
            state <= IDLE;
          end
        end
        FETCH, DATA: begin
          if (count == 4'd0) begin
            state <= IDLE;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

  // Memory port, ready/rdata and stall outputs; forced to zero while in reset
  // so an access cut short by reset never shows a ready pulse.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if_ready  = 1'b0;
    if_rdata  = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    stall_f   = 1'b0;
    stall_m   = 1'b0;
    if (rst_n) begin
      busy = (state == FETCH) || (state == DATA);
      done = busy && (count == 4'd0);
      if (busy) begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_be    = lat_be;
      end else begin
        mem_en = 1'b0;
      end
      if (done && (state == FETCH)) begin
        if_ready = 1'b1;
        if_rdata = mem_rdata;
      end else begin
        if_ready = 1'b0;
      end
      if (done && (state == DATA)) begin
        d_ready = 1'b1;
        d_rdata = mem_rdata;
      end else begin
        d_ready = 1'b0;
      end
      stall_f = if_req && !if_ready;
      stall_m = d_req && !d_ready;
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter with hand-computed
// expectations; a second instance is built with MEM_LATENCY=1.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        stall_f;
  logic        stall_m;

  // Latency-1 instance signals
  logic        f1_if_req;
  logic [31:0] f1_if_rdata;
  logic        f1_if_ready;
  logic [31:0] f1_d_rdata;
  logic        f1_d_ready;
  logic        f1_mem_en;
  logic        f1_mem_we;
  logic [31:0] f1_mem_addr;
  logic [31:0] f1_mem_wdata;
  logic [3:0]  f1_mem_be;
  logic        f1_stall_f;
  logic        f1_stall_m;

  int errors;
  int checks;

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(f1_if_req), .if_addr(32'h0000_0040), .if_rdata(f1_if_rdata), .if_ready(f1_if_ready),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
    .d_rdata(f1_d_rdata), .d_ready(f1_d_ready),
    .mem_en(f1_mem_en), .mem_we(f1_mem_we), .mem_addr(f1_mem_addr), .mem_wdata(f1_mem_wdata),
    .mem_be(f1_mem_be), .mem_rdata(32'h1234_5678),
    .stall_f(f1_stall_f), .stall_m(f1_stall_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs are then driven 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    d_be      = 4'h0;
    mem_rdata = 32'hDEAD_BEEF;
    f1_if_req = 1'b0;

    // Reset: all outputs zero while rst_n is low, even with requests high
    next_cycle();
    next_cycle();
    #1;
    check_val("rst_mem_en",  {31'h0, mem_en},  32'h0);
    check_val("rst_stall_f", {31'h0, stall_f}, 32'h0);
    check_val("rst_stall_m", {31'h0, stall_m}, 32'h0);
    check_val("rst_if_ready",{31'h0, if_ready},32'h0);
    check_val("rst_d_ready", {31'h0, d_ready}, 32'h0);
    check_val("rst_d_rdata", d_rdata, 32'h0);
    check_val("rst_mem_addr",mem_addr, 32'h0);
    rst_n  = 1'b1;
    if_req = 1'b0;
    d_req  = 1'b0;
    next_cycle();

    // Conflict after reset: data first, then fetch
    if_req = 1'b1; if_addr = 32'h0000_0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    mem_rdata = 32'hCAFE_0001;
    #1;
    check_val("cf_T_stall_f", {31'h0, stall_f}, 32'h1);
    check_val("cf_T_mem_en",  {31'h0, mem_en},  32'h0);
    next_cycle(); #1;
    check_val("cf_T1_addr",   mem_addr, 32'h0000_0200);
    check_val("cf_T1_stall_f",{31'h0, stall_f}, 32'h1);
    next_cycle(); #1;
    check_val("cf_T2_d_ready",{31'h0, d_ready}, 32'h1);
    check_val("cf_T2_d_rdata",d_rdata, 32'hCAFE_0001);
    check_val("cf_T2_if_rdy", {31'h0, if_ready}, 32'h0);
    check_val("cf_T2_stall_f",{31'h0, stall_f}, 32'h1);
    check_val("cf_T2_stall_m",{31'h0, stall_m}, 32'h0);
    d_req = 1'b0;
    next_cycle(); #1;
    check_val("cf_T3_mem_en", {31'h0, mem_en}, 32'h0);
    check_val("cf_T3_stall_f",{31'h0, stall_f}, 32'h1);
    next_cycle(); #1;
    check_val("cf_T4_addr",   mem_addr, 32'h0000_0020);
    check_val("cf_T4_be",     {28'h0, mem_be}, 32'h0000_000F);
    check_val("cf_T4_stall_f",{31'h0, stall_f}, 32'h1);
    next_cycle(); #1;
    check_val("cf_T5_if_rdy", {31'h0, if_ready}, 32'h1);
    check_val("cf_T5_if_rdata", if_rdata, 32'hCAFE_0001);
    check_val("cf_T5_d_rdata", d_rdata, 32'h0);
    check_val("cf_T5_stall_f",{31'h0, stall_f}, 32'h0);
    if_req = 1'b0;
    next_cycle();

    // Both requests held: six accesses alternating D,F,D,F,D,F
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int c = 0; c < 18; c++) begin
      #1;
      check_val($sformatf("rr_c%0d_d_ready", c), {31'h0, d_ready},
                ((c % 3 == 2) && ((c / 3) % 2 == 0)) ? 32'h1 : 32'h0);
      check_val($sformatf("rr_c%0d_if_ready", c), {31'h0, if_ready},
                ((c % 3 == 2) && ((c / 3) % 2 == 1)) ? 32'h1 : 32'h0);
      if (c == 17) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      next_cycle();
    end
    #1;
    check_val("rr_end_mem_en", {31'h0, mem_en}, 32'h0);
    next_cycle();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h0050_0093;
    #1;
    check_val("f_T_mem_en", {31'h0, mem_en}, 32'h0);
    next_cycle(); #1;
    check_val("f_T1_mem_en", {31'h0, mem_en}, 32'h1);
    check_val("f_T1_addr",   mem_addr, 32'h0000_0010);
    check_val("f_T1_we",     {31'h0, mem_we}, 32'h0);
    check_val("f_T1_if_rdy", {31'h0, if_ready}, 32'h0);
    check_val("f_T1_if_rdata", if_rdata, 32'h0);
    next_cycle(); #1;
    check_val("f_T2_mem_en", {31'h0, mem_en}, 32'h1);
    check_val("f_T2_if_rdy", {31'h0, if_ready}, 32'h1);
    check_val("f_T2_if_rdata", if_rdata, 32'h0050_0093);
    if_req = 1'b0;
    next_cycle(); #1;
    check_val("f_T3_mem_en", {31'h0, mem_en}, 32'h0);
    check_val("f_T3_if_rdy", {31'h0, if_ready}, 32'h0);
    next_cycle();

    // Store byte; changing inputs mid-access must not disturb the latch
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0103; d_be = 4'b1000;
    d_wdata = 32'hAB00_0000; mem_rdata = 32'h0000_0000;
    next_cycle();
    d_addr = 32'h0000_0FFF; d_be = 4'b0001; d_wdata = 32'h1111_1111;
    #1;
    check_val("st_T1_we",   {31'h0, mem_we}, 32'h1);
    check_val("st_T1_be",   {28'h0, mem_be}, 32'h0000_0008);
    check_val("st_T1_addr", mem_addr, 32'h0000_0103);
    check_val("st_T1_wdata",mem_wdata, 32'hAB00_0000);
    check_val("st_T1_d_rdy",{31'h0, d_ready}, 32'h0);
    next_cycle(); #1;
    check_val("st_T2_we",   {31'h0, mem_we}, 32'h1);
    check_val("st_T2_addr", mem_addr, 32'h0000_0103);
    check_val("st_T2_d_rdy",{31'h0, d_ready}, 32'h1);
    d_req = 1'b0; d_we = 1'b0;
    next_cycle(); #1;
    check_val("st_T3_we",   {31'h0, mem_we}, 32'h0);
    check_val("st_T3_be",   {28'h0, mem_be}, 32'h0);
    next_cycle();

    // Reset in the second cycle of a data access
    d_req = 1'b1; d_addr = 32'h0000_0300; mem_rdata = 32'h5555_AAAA;
    next_cycle(); #1;
    check_val("rd_T1_mem_en", {31'h0, mem_en}, 32'h1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_val("rd_T2_d_ready", {31'h0, d_ready}, 32'h0);
    check_val("rd_T2_d_rdata", d_rdata, 32'h0);
    next_cycle();
    rst_n = 1'b1; d_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0080;
    #1;
    check_val("rd_T3_mem_en", {31'h0, mem_en}, 32'h0);
    check_val("rd_T3_d_ready",{31'h0, d_ready}, 32'h0);
    check_val("rd_T3_mem_addr", mem_addr, 32'h0);
    next_cycle(); #1;
    check_val("rd_T4_addr", mem_addr, 32'h0000_0080);
    next_cycle(); #1;
    check_val("rd_T5_if_rdy", {31'h0, if_ready}, 32'h1);
    check_val("rd_T5_d_rdy",  {31'h0, d_ready}, 32'h0);
    if_req = 1'b0;
    next_cycle();

    // Latency-1 build: fetch held high completes every second cycle
    f1_if_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_val($sformatf("l1_c%0d_if_ready", c), {31'h0, f1_if_ready},
                (c % 2 == 1) ? 32'h1 : 32'h0);
      check_val($sformatf("l1_c%0d_if_rdata", c), f1_if_rdata,
                (c % 2 == 1) ? 32'h1234_5678 : 32'h0);
      next_cycle();
    end
    f1_if_req = 1'b0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
